// File: rtl/aes_seq_ctrl_pkg.sv
// Shared definitions for the AES core sequencer: core register map,
// register bit positions and the sequencer state encoding.
package aes_seq_ctrl_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_CONFIG = 8'h0A;
  localparam logic [7:0] ADDR_KEY    = 8'h10;
  localparam logic [7:0] ADDR_BLOCK  = 8'h20;
  localparam logic [7:0] ADDR_RESULT = 8'h30;

  localparam int CTRL_INIT_BIT     = 0;
  localparam int CTRL_NEXT_BIT     = 1;
  localparam int STATUS_READY_BIT  = 0;
  localparam int STATUS_VALID_BIT  = 1;
  localparam int CONFIG_ENCDEC_BIT = 0;
  localparam int CONFIG_KEYLEN_BIT = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_KEY,
    ST_INIT,
    ST_WAIT_KEY,
    ST_BLK,
    ST_NEXT,
    ST_WAIT_RES,
    ST_RD,
    ST_OUT
  } state_e;

endpackage

// File: rtl/aes_seq_ctrl.sv
// Drives an AES core's register port: key expansion on request, then one block
// per handshake through write/start/poll/read, holding the result until taken.
module aes_seq_ctrl
  import aes_seq_ctrl_pkg::*;
#(
  parameter int POLL_MAX = 1023
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [255:0] key_i,
  input  logic         key_len_i,
  input  logic         encdec_i,
  input  logic         key_load_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         aes_cs_o,
  output logic         aes_we_o,
  output logic [7:0]   aes_addr_o,
  output logic [31:0]  aes_wdata_o,
  input  logic [31:0]  aes_rdata_i,
  output logic         busy_o,
  output logic         key_valid_o,
  output logic         err_o
);

  localparam int PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic [7:0][31:0]  key_q, key_d;
  logic              key_len_q, key_len_d;
  logic              encdec_q, encdec_d;
  logic [3:0][31:0]  blk_q, blk_d;
  logic [127:0]      out_data_q, out_data_d;
  logic              key_valid_q, key_valid_d;
  logic              err_q, err_d;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      poll_q      <= '0;
      key_q       <= '0;
      key_len_q   <= 1'b0;
      encdec_q    <= 1'b0;
      blk_q       <= '0;
      out_data_q  <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      poll_q      <= poll_d;
      key_q       <= key_d;
      key_len_q   <= key_len_d;
      encdec_q    <= encdec_d;
      blk_q       <= blk_d;
      out_data_q  <= out_data_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    poll_d      = poll_q;
    key_d       = key_q;
    key_len_d   = key_len_q;
    encdec_d    = encdec_q;
    blk_d       = blk_q;
    out_data_d  = out_data_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    aes_cs_o    = 1'b0;
    aes_we_o    = 1'b0;
    aes_addr_o  = '0;
    aes_wdata_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        // A key load wins over a waiting block so a stale key is never used.
        if (key_load_i) begin
          key_d       = key_i;
          key_len_d   = key_len_i;
          encdec_d    = encdec_i;
          key_valid_d = 1'b0;
          err_d       = 1'b0;
          state_d     = ST_CFG;
        end else if (in_valid_i && key_valid_q) begin
          blk_d   = in_data_i;
          idx_d   = '0;
          state_d = ST_BLK;
        end
      end
      ST_CFG: begin
        aes_cs_o    = 1'b1;
        aes_we_o    = 1'b1;
        aes_addr_o  = ADDR_CONFIG;
        aes_wdata_o[CONFIG_ENCDEC_BIT] = encdec_q;
        aes_wdata_o[CONFIG_KEYLEN_BIT] = key_len_q;
        idx_d       = '0;
        state_d     = ST_KEY;
      end
      ST_KEY: begin
        aes_cs_o    = 1'b1;
        aes_we_o    = 1'b1;
        aes_addr_o  = ADDR_KEY | {5'b0, idx_q};
        aes_wdata_o = key_q[3'd7 - idx_q];
        idx_d       = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = ST_INIT;
      end
      ST_INIT: begin
        aes_cs_o    = 1'b1;
        aes_we_o    = 1'b1;
        aes_addr_o  = ADDR_CTRL;
        aes_wdata_o[CTRL_INIT_BIT] = 1'b1;
        poll_d      = '0;
        state_d     = ST_WAIT_KEY;
      end
      ST_WAIT_KEY: begin
        aes_cs_o   = 1'b1;
        aes_addr_o = ADDR_STATUS;
        if (aes_rdata_i[STATUS_READY_BIT]) begin
          key_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (poll_q == PW'(POLL_MAX - 1)) begin
          err_d       = 1'b1;
          key_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      ST_BLK: begin
        aes_cs_o    = 1'b1;
        aes_we_o    = 1'b1;
        aes_addr_o  = ADDR_BLOCK | {6'b0, idx_q[1:0]};
        aes_wdata_o = blk_q[2'd3 - idx_q[1:0]];
        idx_d       = idx_q + 3'd1;
        if (idx_q[1:0] == 2'd3) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        aes_cs_o    = 1'b1;
        aes_we_o    = 1'b1;
        aes_addr_o  = ADDR_CTRL;
        aes_wdata_o[CTRL_NEXT_BIT] = 1'b1;
        poll_d      = '0;
        state_d     = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        aes_cs_o   = 1'b1;
        aes_addr_o = ADDR_STATUS;
        if (aes_rdata_i[STATUS_VALID_BIT]) begin
          idx_d   = '0;
          state_d = ST_RD;
        end else if (poll_q == PW'(POLL_MAX - 1)) begin
          err_d       = 1'b1;
          key_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      ST_RD: begin
        // Words arrive MSW first; shifting left lands word 0 in [127:96].
        aes_cs_o   = 1'b1;
        aes_addr_o = ADDR_RESULT | {6'b0, idx_q[1:0]};
        out_data_d = {out_data_q[95:0], aes_rdata_i};
        idx_d      = idx_q + 3'd1;
        if (idx_q[1:0] == 2'd3) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == ST_IDLE) && key_valid_q && !key_load_i;
  assign out_valid_o = (state_q == ST_OUT);
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign key_valid_o = key_valid_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Directed bench for aes_seq_ctrl against a behavioural core stub that logs
// writes, reports status after a programmable delay and returns a canned result.
module tb_aes_seq_ctrl;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic [255:0] key_i = '0;
  logic         key_len_i = 1'b0;
  logic         encdec_i = 1'b0;
  logic         key_load_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [127:0] in_data_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [127:0] out_data_o;
  logic         aes_cs_o, aes_we_o;
  logic [7:0]   aes_addr_o;
  logic [31:0]  aes_wdata_o;
  logic [31:0]  aes_rdata_i;
  logic         busy_o, key_valid_o, err_o;

  aes_seq_ctrl #(.POLL_MAX(15)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .key_i(key_i), .key_len_i(key_len_i), .encdec_i(encdec_i), .key_load_i(key_load_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .aes_cs_o(aes_cs_o), .aes_we_o(aes_we_o), .aes_addr_o(aes_addr_o),
    .aes_wdata_o(aes_wdata_o), .aes_rdata_i(aes_rdata_i),
    .busy_o(busy_o), .key_valid_o(key_valid_o), .err_o(err_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // ---------------- core stub ----------------
  logic [39:0]      wr_log[$];
  int               acc_cnt = 0;
  int               poll_cnt = 0;
  int               accept_cnt = 0;
  int               extra_polls = 0;
  int               stat_cnt = 0;
  logic             core_dead = 1'b0;
  logic [3:0][31:0] res_w = '0;

  always @(posedge wb_clk_i) begin
    if (aes_cs_o) acc_cnt++;
    if (aes_cs_o && !aes_we_o && aes_addr_o == 8'h09) poll_cnt++;
    if (in_valid_i && in_ready_o) accept_cnt++;
    if (aes_cs_o && aes_we_o) wr_log.push_back({aes_addr_o, aes_wdata_o});
    if (aes_cs_o && aes_we_o && aes_addr_o == 8'h08) stat_cnt <= extra_polls;
    else if (stat_cnt > 0) stat_cnt <= stat_cnt - 1;
  end

  always_comb begin
    aes_rdata_i = '0;
    if (aes_addr_o == 8'h09)
      aes_rdata_i = (core_dead || stat_cnt != 0) ? 32'h0 : 32'h3;
    else if (aes_addr_o[7:2] == 6'b001100)
      aes_rdata_i = res_w[2'd3 - aes_addr_o[1:0]];
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_key(input logic [255:0] k, input logic len, input logic enc);
    int n;
    @(negedge wb_clk_i);
    key_i = k; key_len_i = len; encdec_i = enc; key_load_i = 1'b1;
    wr_log.delete(); poll_cnt = 0;
    @(negedge wb_clk_i);
    key_load_i = 1'b0; key_i = '1; key_len_i = ~len; encdec_i = ~enc;
    for (n = 0; n < 200 && busy_o; n++) @(negedge wb_clk_i);
    if (n >= 200) check_eq("key_load_timeout", 1, 0);
  endtask

  task automatic check_key_writes(input logic [255:0] k, input logic [31:0] cfg);
    logic [7:0][31:0] kw;
    kw = k;
    check_eq("key_wr_count", wr_log.size(), 10);
    check_eq("cfg_write", wr_log[0], {8'h0A, cfg});
    for (int i = 0; i < 8; i++)
      check_eq("key_word", wr_log[1+i], {8'h10 + 8'(i), kw[7-i]});
    check_eq("init_write", wr_log[9], {8'h08, 32'h1});
  endtask

  // Accepts one block, checks core traffic and result, optionally stalls the output.
  task automatic send_block(input logic [127:0] blk, input logic [127:0] res,
                            input int exp_acc, input int hold);
    logic [3:0][31:0] bw;
    int n;
    logic bad_v, bad_d, bad_r;
    bw = blk; res_w = res;
    @(negedge wb_clk_i);
    in_data_i = blk; in_valid_i = 1'b1;
    for (n = 0; n < 50 && !in_ready_o; n++) @(negedge wb_clk_i);
    if (n >= 50) check_eq("accept_timeout", 1, 0);
    @(negedge wb_clk_i);
    in_valid_i = 1'b0; in_data_i = '1;
    wr_log.delete(); acc_cnt = 0;
    for (n = 0; n < 200 && !out_valid_o; n++) @(negedge wb_clk_i);
    if (n >= 200) check_eq("result_timeout", 1, 0);
    check_eq("core_accesses", acc_cnt, exp_acc);
    check_eq("blk_wr_count", wr_log.size(), 5);
    for (int i = 0; i < 4; i++)
      check_eq("blk_word", wr_log[i], {8'h20 + 8'(i), bw[3-i]});
    check_eq("next_write", wr_log[4], {8'h08, 32'h2});
    check_eq("out_data", out_data_o, res);
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int c = 0; c < hold; c++) begin
      @(negedge wb_clk_i);
      if (out_valid_o !== 1'b1) bad_v = 1;
      if (out_data_o !== res) bad_d = 1;
      if (in_ready_o !== 1'b0) bad_r = 1;
    end
    if (hold > 0) begin
      check_eq("hold_valid_dropped", bad_v, 0);
      check_eq("hold_data_changed", bad_d, 0);
      check_eq("hold_in_ready_seen", bad_r, 0);
    end
    out_ready_i = 1'b1;
    @(negedge wb_clk_i);
    out_ready_i = 1'b0;
    check_eq("in_ready_after_take", in_ready_o, 1);
    check_eq("out_valid_after_take", out_valid_o, 0);
  endtask

  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    int n, acc0;
    // reset values
    #2;
    check_eq("rst_flags", {in_ready_o, out_valid_o, busy_o, key_valid_o, err_o, aes_cs_o, aes_we_o}, 7'b0);
    check_eq("rst_bus", {aes_addr_o, aes_wdata_o}, 40'h0);
    check_eq("rst_out_data", out_data_o, 128'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // 128-bit key, encrypt
    load_key(KEY128, 1'b0, 1'b1);
    check_key_writes(KEY128, 32'h1);
    check_eq("key_valid", key_valid_o, 1);
    check_eq("key_polls", poll_cnt, 1);
    // best case: 4 writes + next + 1 poll + 4 reads
    send_block(PT, CT, 10, 20);

    // decrypt with the same key, three extra polls
    load_key(KEY128, 1'b0, 1'b0);
    check_eq("cfg_dec", wr_log[0], {8'h0A, 32'h0});
    extra_polls = 3;
    send_block(CT, PT, 13, 0);
    extra_polls = 0;

    // 256-bit key, decrypt: config bit1 set, all eight words distinct
    load_key(KEY256, 1'b1, 1'b0);
    check_key_writes(KEY256, 32'h2);

    // key load and block offered together: key sequence runs first
    @(negedge wb_clk_i);
    res_w = CT;
    key_i = KEY128; key_len_i = 1'b0; encdec_i = 1'b1; key_load_i = 1'b1;
    in_data_i = PT; in_valid_i = 1'b1;
    wr_log.delete(); accept_cnt = 0;
    #1 check_eq("in_ready_during_load", in_ready_o, 0);
    @(negedge wb_clk_i);
    key_load_i = 1'b0;
    for (n = 0; n < 300 && !out_valid_o; n++) begin
      @(negedge wb_clk_i);
      if (accept_cnt != 0) in_valid_i = 1'b0;
    end
    in_valid_i = 1'b0;
    if (n >= 300) check_eq("both_timeout", 1, 0);
    check_eq("both_first_cfg", wr_log[0], {8'h0A, 32'h1});
    check_eq("both_wr_count", wr_log.size(), 15);
    check_eq("both_blk_after_key", wr_log[10][39:32], 8'h20);
    check_eq("both_out", out_data_o, CT);
    out_ready_i = 1'b1;
    @(negedge wb_clk_i);
    out_ready_i = 1'b0;

    // reset pulse in the middle of block writes
    @(negedge wb_clk_i);
    in_data_i = PT; in_valid_i = 1'b1;
    @(negedge wb_clk_i);
    in_valid_i = 1'b0;
    @(negedge wb_clk_i);
    check_eq("mid_blk_write", {busy_o, aes_cs_o, aes_we_o, aes_addr_o[7:4]}, {3'b111, 4'h2});
    #1 wb_rst_i = 1'b1;
    #1;
    check_eq("arst_flags", {in_ready_o, out_valid_o, busy_o, key_valid_o, err_o, aes_cs_o, aes_we_o}, 7'b0);
    check_eq("arst_bus", {aes_addr_o, aes_wdata_o, out_data_o}, 168'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    acc0 = acc_cnt;
    in_valid_i = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge wb_clk_i);
      if (in_ready_o || busy_o) n++;
    end
    in_valid_i = 1'b0;
    check_eq("post_rst_accesses", acc_cnt - acc0, 0);
    check_eq("post_rst_blocked", n, 0);

    // dead core: poll timeout
    core_dead = 1'b1;
    load_key(KEY128, 1'b0, 1'b1);
    check_eq("timeout_polls", poll_cnt, 15);
    check_eq("timeout_state", {err_o, key_valid_o, in_ready_o}, 3'b100);
    repeat (5) @(negedge wb_clk_i);
    check_eq("err_sticky", err_o, 1);
    core_dead = 1'b0;
    load_key(KEY128, 1'b0, 1'b1);
    check_eq("err_cleared", {err_o, key_valid_o}, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
